// File: rtl/memory_port_arbiter.sv
// Single-bus arbiter between instruction fetch and the memory stage (data side has priority).
// Optional MISALIGN_CHECK_EN: misaligned requests complete immediately with an error instead of being force-aligned.
module memory_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchRequest,
    input  logic [31:0] fetchAddress,
    output logic        fetchReady,
    output logic [31:0] fetchData,
    output logic        fetchError,
    input  logic        flush,
    input  logic        dataRequest,
    input  logic        dataWrite,
    input  logic [31:0] dataAddress,
    input  logic [1:0]  dataWidth,
    input  logic        dataSigned,
    input  logic [31:0] dataStoreData,
    output logic        dataReady,
    output logic [31:0] dataLoadData,
    output logic        dataError,
    output logic        busRequest,
    output logic        busWrite,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    output logic [3:0]  busByteEnable,
    input  logic [31:0] busReadData,
    input  logic        busAcknowledge
);
    typedef enum logic [1:0] {IDLE, BUS, RESPOND} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;      // 1 = data side owns the transaction
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  width_q, width_d;
    logic        signed_q, signed_d;
    logic [1:0]  lo_q, lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        squash_q, squash_d;

    logic        g_data, g_fetch, grant, g_write;
    logic [31:0] g_addr, g_wd;
    logic [1:0]  g_width, g_lo;
    logic [3:0]  g_be;
    logic [16:0] cnt_inc;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic        resp;
`ifdef MISALIGN_CHECK_EN
    logic        g_misalign;
`endif

    // Attributes of whichever requester would win this cycle.
    always_comb begin
        g_data  = dataRequest;
        g_fetch = fetchRequest & ~flush;
        grant   = g_data | g_fetch;
        g_addr  = g_data ? dataAddress : fetchAddress;
        g_width = g_data ? dataWidth : 2'b10;
        g_write = g_data & dataWrite;
        case (g_width)
            2'b00:   g_lo = g_addr[1:0];
            2'b01:   g_lo = {g_addr[1], 1'b0};
            default: g_lo = 2'b00;
        endcase
        g_be = 4'b1111;
        g_wd = '0;
        if (g_write) begin
            case (g_width)
                2'b00: begin
                    g_be = 4'b0001 << g_lo;
                    g_wd = {4{dataStoreData[7:0]}};
                end
                2'b01: begin
                    g_be = 4'b0011 << g_lo;
                    g_wd = {2{dataStoreData[15:0]}};
                end
                default: g_wd = dataStoreData;
            endcase
        end
`ifdef MISALIGN_CHECK_EN
        g_misalign = ((g_width == 2'b01) && g_addr[0]) ||
                     (g_width[1] && (g_addr[1:0] != 2'b00));
`endif
    end

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        width_d  = width_q;
        signed_d = signed_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        squash_d = squash_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d  = g_data;
                    write_d  = g_write;
                    addr_d   = {g_addr[31:2], 2'b00};
                    wdata_d  = g_wd;
                    be_d     = g_be;
                    width_d  = g_width;
                    signed_d = g_data & dataSigned;
                    lo_d     = g_lo;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    rdata_d  = '0;
                    squash_d = 1'b0;
                    state_d  = BUS;
`ifdef MISALIGN_CHECK_EN
                    if (g_misalign) begin
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end
`endif
                end
            end
            BUS: begin
                if (!owner_q && flush) squash_d = 1'b1;
                if (busAcknowledge) begin
                    rdata_d = busReadData;
                    state_d = RESPOND;
                end else if (cnt_inc == 17'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            RESPOND: begin
                if (!owner_q && flush) squash_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            width_q  <= '0;
            signed_q <= 1'b0;
            lo_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        case (lo_q)
            2'd0:    lane_b = rdata_q[7:0];
            2'd1:    lane_b = rdata_q[15:8];
            2'd2:    lane_b = rdata_q[23:16];
            default: lane_b = rdata_q[31:24];
        endcase
        lane_h = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (width_q)
            2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_ext = rdata_q;
        endcase
    end

    // A flush arriving in the response cycle itself also hides the fetch pulse.
    assign resp         = (state_q == RESPOND);
    assign fetchReady   = resp & ~owner_q & ~squash_q & ~flush;
    assign fetchError   = fetchReady & err_q;
    assign fetchData    = (fetchReady & ~err_q) ? rdata_q : '0;
    assign dataReady    = resp & owner_q;
    assign dataError    = dataReady & err_q;
    assign dataLoadData = (dataReady & ~err_q & ~write_q) ? load_ext : '0;

    assign busRequest    = (state_q == BUS);
    assign busWrite      = write_q;
    assign busAddress    = addr_q;
    assign busWriteData  = wdata_q;
    assign busByteEnable = be_q;
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the core's single memory bus between instruction fetch and the memory stage. It serialises one transaction at a time through a three-state FSM, giving priority to the data side. For loads and stores it handles byte-lane placement, byte enables and load sign/zero extension. It also applies a bus-timeout and an optional misalignment check, and returns per-requester ready/error pulses that the pipeline uses to build its stall control.

## Interface
- TIMEOUT_CYCLES, 255: number of BUS-state cycles without acknowledge before the transaction is abandoned with an error; range 1..65535.
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetchRequest  in  1  fetch wants a 32-bit instruction read; held until fetchReady or flush.
- fetchAddress  in  32  instruction address.
- fetchReady  out  1  one-cycle pulse; fetchData/fetchError valid.
- fetchData  out  32  instruction word.
- fetchError  out  1  fetch failed (timeout, or misaligned when checked).
- flush  in  1  squashes any outstanding or pending fetch.
- dataRequest  in  1  memory stage wants a load/store; held with attributes stable until dataReady.
- dataWrite  in  1  1 = store, 0 = load.
- dataAddress  in  32  byte address.
- dataWidth  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- dataSigned  in  1  sign-extend load result.
- dataStoreData  in  32  store value, right-aligned.
- dataReady  out  1  one-cycle pulse; dataLoadData/dataError valid.
- dataLoadData  out  32  extended load result; 0 for stores and errors.
- dataError  out  1  data access failed.
- busRequest  out  1  transaction active; held until busAcknowledge or timeout.
- busWrite  out  1  store cycle.
- busAddress  out  32  word address, bits [1:0] = 0.
- busWriteData  out  32  lane-replicated store data.
- busByteEnable  out  4  active byte lanes; 1111 on reads.
- busReadData  in  32  read data, valid with busAcknowledge.
- busAcknowledge  in  1  completes the current transaction.

## Operation
- States: IDLE, BUS, RESPOND.
- IDLE:
  - dataRequest wins over fetchRequest. Fetch is not granted while flush=1.
  - On a grant, register the word address, write flag, lane data and enables, width, signed flag, low address bits and the owner, then go to BUS.
  - With no request, stay in IDLE.
- BUS:
  - busRequest=1 and the timeout counter increments each cycle.
  - On busAcknowledge: capture busReadData, go to RESPOND.
  - When the counter reaches TIMEOUT_CYCLES: drop busRequest, set the error flag, go to RESPOND.
- RESPOND:
  - Pulse the owner's ready output, with error and data, for exactly one cycle.
  - Never grant in this state. Return to IDLE.
- Store lanes:
  - Byte: data replicated ×4; enables 0001<<addr[1:0].
  - Half: data replicated ×2; enables 0011<<{addr[1],0}.
  - Word: enables 1111.
- Load extraction: byte lane addr[1:0], half lane addr[1]; sign- or zero-extend per dataSigned.
- Flush:
  - Flush in BUS or RESPOND while the owner is fetch sets a squash flag. fetchReady is then suppressed, but the bus transaction still completes.
  - Data transactions are never squashed.
- busAcknowledge outside BUS is ignored.

## Timing
- Reset values: state IDLE; every output 0. busRequest clears asynchronously, including mid-transaction.
- Latency:
  - Request seen in IDLE at cycle 0 → busRequest high from cycle 1.
  - Acknowledge in cycle k → ready pulse in cycle k+1.
  - Minimum request-to-ready is 2 cycles; minimum spacing between grants is 3 cycles.
- Bus attributes are registered and stable for the whole BUS state.
- Simultaneous fetch and data requests: data is granted first. Fetch is granted at the next IDLE if still requested.
- Timeout: busRequest falls in the cycle after the count hits TIMEOUT_CYCLES; the ready pulse with error=1 follows in the next cycle.

## Configuration
- MISALIGN_CHECK_EN defined:
  - In IDLE, a half access with addr[0]=1, a word access with addr[1:0]≠0, or a fetch with addr[1:0]≠0 goes directly to RESPOND with no bus transaction.
  - That request gets error=1 and data 0; ready follows one cycle after the request.
- MISALIGN_CHECK_EN undefined:
  - Offending low bits are forced to zero: a half access uses addr[1] only, word accesses and fetches ignore addr[1:0].
  - No misalignment error is generated.

## Test plan
- Fetch at 0x100, ack 1 cycle after busRequest, busReadData=0x00500093 → fetchReady 2 cycles after the request, fetchData=0x00500093, busByteEnable=1111.
- Fetch and load requested in the same cycle → load transaction first, dataReady, then fetch busRequest ≥3 cycles after the first grant.
- Signed byte load at 0x203, busReadData=0x80FFFFFF → dataLoadData=0xFFFFFF80. Unsigned halfword at 0x202 → 0x000080FF.
- Halfword store 0xBEEF at 0x306 → busAddress 0x304, busWriteData 0xBEEFBEEF, busByteEnable 1100.
- TIMEOUT_CYCLES=4, no acknowledge → busRequest drops after 4 BUS cycles, then dataReady with dataError=1 and dataLoadData=0. A late acknowledge has no effect.
- Flush during fetch BUS, then ack → no fetchReady pulse; FSM back in IDLE. With MISALIGN_CHECK_EN, a word load at 0x2 gives dataError=1 with no busRequest.
